// File: rtl/sync_skew_pkg.sv
// Shared types for the camera frame-start skew detector.
// State encoding, skew counter type and err-pair encodings.
package sync_skew_pkg;

    localparam int CNT_W = 23;

    typedef logic [CNT_W-1:0] skew_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EDGE,
        MEAS_0F,
        MEAS_1F,
        EVAL,
        TOUT
    } state_t;

    // {err_ch1, err_ch0}; ERR_CH0 and ERR_CH1 are never combined
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CH0  = 2'b01;
    localparam logic [1:0] ERR_CH1  = 2'b10;

    function automatic logic [1:0] err_next(
        input skew_t      skew,
        input logic       lag_ch1,
        input logic [1:0] cur,
        input skew_t      tol_on,
        input skew_t      tol_off
    );
        if (skew > tol_on)
            return lag_ch1 ? ERR_CH1 : ERR_CH0;
        if (skew <= tol_off)
            return ERR_NONE;
        return cur;
    endfunction

endpackage

// File: rtl/sync_skew_detect_if.sv
// Frame-sync inputs and skew status outputs of sync_skew_detect.
// Status fields exist only when SKEW_STATUS_EN is defined.
interface sync_skew_detect_if;
    import sync_skew_pkg::*;

    logic en;
    logic vsync_0;
    logic vsync_1;
    logic err_ch0;
    logic err_ch1;
    logic timeout;
`ifdef SKEW_STATUS_EN
    skew_t skew_val;
    logic  skew_lag;
    logic  skew_vld;
`endif

    modport master (
        output en, vsync_0, vsync_1,
`ifdef SKEW_STATUS_EN
        input  skew_val, skew_lag, skew_vld,
`endif
        input  err_ch0, err_ch1, timeout
    );

    modport slave (
        input  en, vsync_0, vsync_1,
`ifdef SKEW_STATUS_EN
        output skew_val, skew_lag, skew_vld,
`endif
        output err_ch0, err_ch1, timeout
    );

endinterface

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer plus edge register for an async level input.
// rise_o is a single-cycle pulse per synchronized rising edge.
module sync_rise_det (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/sync_skew_detect.sv
// Frame-start skew detector between two camera channels with hysteretic err.
// Define SKEW_STATUS_EN to export the last skew value, lagger and valid pulse.
module sync_skew_detect
    import sync_skew_pkg::*;
#(
    parameter int unsigned FREQ     = 240,
    parameter int unsigned MAX_SKEW = FREQ * 50_000 / 3,
    parameter int unsigned TOL_ON   = 64,
    parameter int unsigned TOL_OFF  = 16
) (
    input logic               clk,
    input logic               reset_n,
    sync_skew_detect_if.slave bus
);

    localparam skew_t MAX_C = skew_t'(MAX_SKEW);
    localparam skew_t ON_C  = skew_t'(TOL_ON);
    localparam skew_t OFF_C = skew_t'(TOL_OFF);

    logic       rise0;
    logic       rise1;
    state_t     state_q;
    skew_t      cnt_q;
    skew_t      meas_q;
    skew_t      meas_d;
    logic       lag_q;
    logic       lag_d;
    logic       hit;
    logic [1:0] err_q;
    logic       tout_q;

    sync_rise_det u_rise0 (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus.vsync_0),
        .rise_o  (rise0)
    );

    sync_rise_det u_rise1 (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus.vsync_1),
        .rise_o  (rise1)
    );

    // hit: a complete edge pair is seen this cycle and EVAL is next
    always_comb begin
        hit    = 1'b0;
        meas_d = meas_q;
        lag_d  = lag_q;
        if (bus.en) begin
            unique case (state_q)
                WAIT_EDGE: if (rise0 & rise1) begin
                    hit    = 1'b1;
                    meas_d = '0;
                    lag_d  = 1'b0;
                end
                MEAS_0F: if (rise1) begin
                    hit    = 1'b1;
                    meas_d = cnt_q;
                    lag_d  = 1'b1;
                end
                MEAS_1F: if (rise0) begin
                    hit    = 1'b1;
                    meas_d = cnt_q;
                    lag_d  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            meas_q  <= '0;
            lag_q   <= 1'b0;
            err_q   <= ERR_NONE;
            tout_q  <= 1'b0;
        end else begin
            tout_q <= 1'b0;
            meas_q <= meas_d;
            lag_q  <= lag_d;
            if (!bus.en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                err_q   <= ERR_NONE;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= WAIT_EDGE;
                    WAIT_EDGE: begin
                        if (hit) begin
                            state_q <= EVAL;
                        end else if (rise0) begin
                            cnt_q   <= skew_t'(1);
                            state_q <= MEAS_0F;
                        end else if (rise1) begin
                            cnt_q   <= skew_t'(1);
                            state_q <= MEAS_1F;
                        end
                    end
                    MEAS_0F, MEAS_1F: begin
                        if (hit) begin
                            state_q <= EVAL;
                        end else if (cnt_q == MAX_C) begin
                            state_q <= TOUT;
                            tout_q  <= 1'b1;
                            err_q   <= ERR_NONE;
                        end else begin
                            cnt_q <= cnt_q + skew_t'(1);
                        end
                    end
                    EVAL: begin
                        err_q   <= err_next(meas_q, lag_q, err_q,
                                            ON_C, OFF_C);
                        state_q <= WAIT_EDGE;
                    end
                    TOUT: state_q <= WAIT_EDGE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.err_ch0 = err_q[0];
    assign bus.err_ch1 = err_q[1];
    assign bus.timeout = tout_q;

`ifdef SKEW_STATUS_EN
    skew_t skew_val_q;
    logic  skew_lag_q;
    logic  skew_vld_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skew_val_q <= '0;
            skew_lag_q <= 1'b0;
            skew_vld_q <= 1'b0;
        end else begin
            skew_vld_q <= hit;
            if (hit) begin
                skew_val_q <= meas_d;
                skew_lag_q <= lag_d;
            end
        end
    end

    assign bus.skew_val = skew_val_q;
    assign bus.skew_lag = skew_lag_q;
    assign bus.skew_vld = skew_vld_q;
`endif

endmodule

// File: tb/tb_sync_skew_detect.sv
// Scenario bench for sync_skew_detect: expected err per frame pair is
// queued when the edges are driven and checked when the err update lands.
module tb_sync_skew_detect;
    import sync_skew_pkg::*;

    localparam int unsigned MAXS = 1000;

    typedef struct {
        logic [1:0] err;
        int         skew;
        logic       lag;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    sync_skew_detect_if bus ();

    sync_skew_detect #(
        .FREQ     (240),
        .MAX_SKEW (MAXS),
        .TOL_ON   (64),
        .TOL_OFF  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            vectors++;
            if ((bus.err_ch0 & bus.err_ch1) !== 1'b0) begin
                miscompares++;
                $display("FAIL both_err at %0t: err_ch0=%b err_ch1=%b, required not both 1",
                         $time, bus.err_ch0, bus.err_ch1);
            end
        end
    end

    function automatic logic [1:0] errs();
        return {bus.err_ch1, bus.err_ch0};
    endfunction

    // ch1_lags selects which vsync rises d clocks later; d=0 means same cycle
    task automatic do_frame(input string nm, input int d,
                            input logic ch1_lags, input logic [1:0] exp);
        exp_t       e;
        logic [1:0] prev;
        logic       saw_to;
        e.err  = exp;
        e.skew = d;
        e.lag  = (d != 0) ? ch1_lags : 1'b0;
        sb.push_back(e);
        @(negedge clk);
        prev   = errs();
        saw_to = 1'b0;
        if (d == 0) begin
            bus.vsync_0 = 1'b1;
            bus.vsync_1 = 1'b1;
        end else begin
            if (ch1_lags) bus.vsync_0 = 1'b1;
            else          bus.vsync_1 = 1'b1;
            repeat (d) begin
                @(negedge clk);
                saw_to |= bus.timeout;
            end
            if (ch1_lags) bus.vsync_1 = 1'b1;
            else          bus.vsync_0 = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            saw_to |= bus.timeout;
        end
        vectors++;
        if (errs() !== prev) begin
            miscompares++;
            $display("FAIL %s_early: err=%b, required unchanged %b", nm, errs(), prev);
        end
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s_sb: queue empty, required one entry", nm);
            return;
        end
        e = sb.pop_front();
`ifdef SKEW_STATUS_EN
        vectors++;
        if (bus.skew_vld !== 1'b1 || bus.skew_val !== skew_t'(e.skew)
            || bus.skew_lag !== e.lag) begin
            miscompares++;
            $display("FAIL %s_status: vld=%b val=%0d lag=%b, required 1 %0d %b",
                     nm, bus.skew_vld, bus.skew_val, bus.skew_lag, e.skew, e.lag);
        end
`endif
        @(negedge clk);
        saw_to |= bus.timeout;
        vectors++;
        if (errs() !== e.err) begin
            miscompares++;
            $display("FAIL %s_err: err={ch1,ch0}=%b, required %b", nm, errs(), e.err);
        end
        vectors++;
        if (saw_to !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_timeout: saw timeout=%b, required 0", nm, saw_to);
        end
        bus.vsync_0 = 1'b0;
        bus.vsync_1 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.en      = 1'b0;
        bus.vsync_0 = 1'b0;
        bus.vsync_1 = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({errs(), bus.timeout} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_out: err=%b timeout=%b, required 00 0", errs(), bus.timeout);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({errs(), bus.timeout} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle: err=%b timeout=%b, required 00 0", errs(), bus.timeout);
        end
        bus.en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        do_frame("basic_100", 100, 1'b1, ERR_CH1);
    endtask

    task automatic test_same_cycle();
        do_frame("same_0", 0, 1'b1, ERR_NONE);
    endtask

    task automatic test_hysteresis();
        do_frame("hyst_100", 100, 1'b1, ERR_CH1);
        do_frame("hyst_40", 40, 1'b1, ERR_CH1);
        do_frame("hyst_10", 10, 1'b1, ERR_NONE);
    endtask

    task automatic test_timeout();
        int   n;
        logic found;
        do_frame("to_pre", 100, 1'b1, ERR_CH1);
        @(negedge clk);
        bus.vsync_0 = 1'b1;
        n     = 0;
        found = 1'b0;
        while (n < MAXS + 100 && !found) begin
            @(negedge clk);
            n++;
            if (bus.timeout) found = 1'b1;
        end
        vectors++;
        if (!found || n !== MAXS + 3) begin
            miscompares++;
            $display("FAIL to_latency: found=%b after %0d clks, required 1 after %0d",
                     found, n, MAXS + 3);
        end
        vectors++;
        if (errs() !== ERR_NONE) begin
            miscompares++;
            $display("FAIL to_err: err=%b, required 00", errs());
        end
        @(negedge clk);
        vectors++;
        if (bus.timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL to_pulse: timeout=%b one clk later, required 0", bus.timeout);
        end
        bus.vsync_0 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_switch();
        do_frame("sw_ch0", 100, 1'b0, ERR_CH0);
        do_frame("sw_ch1", 200, 1'b1, ERR_CH1);
    endtask

    task automatic test_enable();
        do_frame("en_pre", 100, 1'b1, ERR_CH1);
        @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        vectors++;
        if ({errs(), bus.timeout} !== 3'b000) begin
            miscompares++;
            $display("FAIL en_clear: err=%b timeout=%b, required 00 0", errs(), bus.timeout);
        end
        bus.en = 1'b1;
        repeat (4) @(negedge clk);
        do_frame("en_post", 90, 1'b0, ERR_CH0);
    endtask

    task automatic test_reset_mid();
        do_frame("rst_pre", 100, 1'b1, ERR_CH1);
        @(negedge clk);
        bus.vsync_0 = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        reset_n     = 1'b0;
        bus.vsync_0 = 1'b0;
        #1;
        vectors++;
        if ({errs(), bus.timeout} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_async: err=%b timeout=%b, required 00 0", errs(), bus.timeout);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        do_frame("rst_p1", 0, 1'b1, ERR_NONE);
        do_frame("rst_p2", 80, 1'b1, ERR_CH1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_hysteresis();
        test_timeout();
        test_switch();
        test_enable();
        test_reset_mid();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
